// File: rtl/pwm_dac_pkg.sv
// Purpose: shared constants for the PWM DAC (sample width, prescale, counter limits).
// Latency: none, package only.
// Backpressure: not applicable.
package pwm_dac_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int DIV_DEFAULT    = 1;

    // Largest period-counter value for a given sample width.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX        = cnt_max(DATA_W_DEFAULT);
    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/pwm_dac_prescaler.sv
// Purpose: divides clk into a one-cycle tick every DIV cycles.
// Latency: tick is combinational from div_cnt; with DIV=1 it is high every cycle.
// Backpressure: none, free running.
//
// Ports: clk, rst (sync, active-high), tick (out).
module pwm_dac_prescaler
    import pwm_dac_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_dac.sv
// Purpose: double-buffered sample input driving a 2^DATA_W-tick PWM output.
// Latency: a sample reaches pwm_out at the next period boundary (+1 clk), or one period later if a sample is already pending.
// Backpressure: sample_ready is low while a sample is pending; it depends on registers only, never on sample_valid.
//
// Ports: clk, rst (sync, active-high), sample_in/sample_valid/sample_ready (handshake in),
//        pwm_out (registered PWM), period_start and underrun (one-cycle pulses).
// Optional: define PWM_DAC_UNDERRUN_CNT_EN to add underrun_cnt, a saturating 16-bit underrun count.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DIV    = DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              pwm_out,
    output logic              period_start,
    output logic              underrun
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

    localparam logic [DATA_W-1:0] CNT_TOP = DATA_W'(cnt_max(DATA_W));

    logic              tick;
    logic              boundary;
    logic              xfer;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] pend;
    logic              pend_valid;

    pwm_dac_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign boundary     = tick && (cnt == CNT_TOP);
    assign sample_ready = !pend_valid && !rst;
    assign xfer         = sample_valid && sample_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            active       <= '0;
            pend         <= '0;
            pend_valid   <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            // Compare uses the pre-edge active value, so the new duty
            // shows up on pwm_out one clk after the boundary.
            pwm_out      <= (cnt < active);
            period_start <= boundary;
            underrun     <= boundary && !pend_valid;
            // Load and transfer are mutually exclusive: a load needs
            // pend_valid=1, which holds sample_ready low.
            if (boundary && pend_valid) begin
                active     <= pend;
                pend_valid <= 1'b0;
            end else if (xfer) begin
                pend       <= sample_in;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef PWM_DAC_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (boundary && !pend_valid && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// Purpose: self-checking bench for pwm_dac (DIV=1 and DIV=4 instances).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the upstream driver holds each sample until sample_ready accepts it.
module tb_pwm_dac;
    import pwm_dac_pkg::*;

    localparam int PER = CNT_MAX + 1;
    localparam int UC_MAX = (1 << UNDERRUN_CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [7:0] din_a, din_b;
    logic       vld_a, vld_b;
    logic       rdy_a, rdy_b, pwm_a, pwm_b, ps_a, ps_b, ur_a, ur_b;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [15:0] uc_a, uc_b;
`endif

    pwm_dac #(.DATA_W(8), .DIV(1)) u_a (
        .clk(clk), .rst(rst_a), .sample_in(din_a), .sample_valid(vld_a),
        .sample_ready(rdy_a), .pwm_out(pwm_a), .period_start(ps_a), .underrun(ur_a)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        , .underrun_cnt(uc_a)
`endif
    );

    pwm_dac #(.DATA_W(8), .DIV(4)) u_b (
        .clk(clk), .rst(rst_b), .sample_in(din_b), .sample_valid(vld_b),
        .sample_ready(rdy_b), .pwm_out(pwm_b), .period_start(ps_b), .underrun(ur_b)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        , .underrun_cnt(uc_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset, one-slot pending buffer, active duty.
    int m_div[2] = '{1, 4};
    int m_n[2];
    int m_act[2];
    bit m_pv[2];
    int m_pd[2];
    int m_uc[2];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Advance one clock; model predicts the post-edge outputs from the
    // pre-edge inputs, then every output of both instances is compared.
    task automatic step();
        bit rs[2], vl[2];
        int dv[2];
        bit e_pwm[2], e_ps[2], e_ur[2];
        bit g_pwm[2], g_ps[2], g_ur[2], g_rdy[2];
        int g_uc[2];
        rs[0] = rst_a; rs[1] = rst_b;
        vl[0] = vld_a; vl[1] = vld_b;
        dv[0] = din_a; dv[1] = din_b;
        for (int i = 0; i < 2; i++) begin
            if (rs[i]) begin
                e_pwm[i] = 0; e_ps[i] = 0; e_ur[i] = 0;
                m_n[i] = 0; m_act[i] = 0; m_pv[i] = 0; m_pd[i] = 0; m_uc[i] = 0;
            end else begin
                int per;
                int phase;
                bit bnd;
                per   = PER * m_div[i];
                bnd   = ((m_n[i] + 1) % per) == 0;
                phase = (m_n[i] / m_div[i]) % PER;
                e_pwm[i] = phase < m_act[i];
                e_ps[i]  = bnd;
                e_ur[i]  = bnd && !m_pv[i];
                if (e_ur[i] && m_uc[i] < UC_MAX) m_uc[i]++;
                if (bnd && m_pv[i]) begin
                    m_act[i] = m_pd[i];
                    m_pv[i]  = 0;
                end else if (vl[i] && !m_pv[i]) begin
                    m_pd[i] = dv[i];
                    m_pv[i] = 1;
                end
                m_n[i]++;
            end
        end
        @(posedge clk);
        #1;
        g_pwm[0] = pwm_a; g_pwm[1] = pwm_b;
        g_ps[0]  = ps_a;  g_ps[1]  = ps_b;
        g_ur[0]  = ur_a;  g_ur[1]  = ur_b;
        g_rdy[0] = rdy_a; g_rdy[1] = rdy_b;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        g_uc[0] = uc_a; g_uc[1] = uc_b;
`else
        g_uc[0] = 0; g_uc[1] = 0;
`endif
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pwm_out[%0d]", i), g_pwm[i], e_pwm[i]);
            chk($sformatf("period_start[%0d]", i), g_ps[i], e_ps[i]);
            chk($sformatf("underrun[%0d]", i), g_ur[i], e_ur[i]);
            chk($sformatf("sample_ready[%0d]", i), g_rdy[i], (!rs[i] && !m_pv[i]) ? 1 : 0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
            chk($sformatf("underrun_cnt[%0d]", i), g_uc[i], m_uc[i]);
`else
            if (g_uc[i] != 0) chk("uc_unused", g_uc[i], 0);
`endif
        end
    endtask

    task automatic push(input int i, input logic [7:0] v, input int budget);
        bit acc;
        acc = 0;
        if (i == 0) begin vld_a = 1; din_a = v; end
        else        begin vld_b = 1; din_b = v; end
        for (int k = 0; k < budget && !acc; k++) begin
            #1;
            acc = (i == 0) ? rdy_a : rdy_b;
            step();
        end
        if (i == 0) vld_a = 0; else vld_b = 0;
        chk("push_accepted", acc, 1);
    endtask

    task automatic wait_ps(input int i, input int budget, output bit ur_seen);
        bit got;
        got = 0;
        ur_seen = 0;
        for (int k = 0; k < budget && !got; k++) begin
            step();
            got = (i == 0) ? ps_a : ps_b;
            if (got) ur_seen = (i == 0) ? ur_a : ur_b;
        end
        chk("period_start_seen", got, 1);
    endtask

    task automatic count_hi(input int i, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            hi += (i == 0) ? int'(pwm_a) : int'(pwm_b);
        end
    endtask

    typedef struct {
        logic [7:0] smp;
        int         highs;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   hi;
        bit   ur;
        vt[0] = '{8'h40, 64};
        vt[1] = '{8'h00, 0};
        vt[2] = '{8'hFF, 255};
        vt[3] = '{8'h01, 1};
        vt[4] = '{8'h80, 128};
        vt[5] = '{8'h10, 16};

        rst_a = 1; rst_b = 1; vld_a = 0; vld_b = 0; din_a = 0; din_b = 0;
        step();
        step();
        chk("reset_ready_a", rdy_a, 0);
        chk("reset_pwm_a", pwm_a, 0);
        rst_a = 0; rst_b = 0;

        // Duty table: each sample is loaded at the next boundary and held for one period.
        for (int v = 0; v < 6; v++) begin
            push(0, vt[v].smp, 600);
            wait_ps(0, 600, ur);
            chk("load_not_underrun", ur, 0);
            count_hi(0, PER, hi);
            chk($sformatf("highs_%02h", vt[v].smp), hi, vt[v].highs);
            chk("period_len", ps_a, 1);
        end

        // Back-to-back 0x10, 0x20 with valid held.
        push(0, 8'h10, 10);
        vld_a = 1; din_a = 8'h20;
        #1;
        chk("rdy_drop", rdy_a, 0);
        wait_ps(0, 600, ur);
        chk("rdy_rise", rdy_a, 1);
        step();
        hi = int'(pwm_a);
        vld_a = 0;
        for (int k = 0; k < PER - 1; k++) begin
            step();
            hi += int'(pwm_a);
        end
        chk("b2b_first_highs", hi, 16);
        chk("b2b_second_load", ps_a, 1);
        count_hi(0, PER, hi);
        chk("b2b_second_highs", hi, 32);

        // Underrun: one sample then silence.
        rst_a = 1; step(); rst_a = 0;
        push(0, 8'h80, 10);
        wait_ps(0, 600, ur);
        chk("ur_first_load", ur, 0);
        count_hi(0, PER, hi);
        chk("ur_duty", hi, 128);
        chk("ur_pulse_1", ur_a, 1);
        wait_ps(0, 300, ur);
        chk("ur_pulse_2", ur, 1);
        wait_ps(0, 300, ur);
        chk("ur_pulse_3", ur, 1);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        chk("ur_cnt_3", uc_a, 3);
`endif

        // Reset mid-period with 0x80 active and 0x30 pending.
        wait_ps(0, 300, ur);
        push(0, 8'h30, 10);
        for (int k = 0; k < 300 && (m_n[0] % PER) != 100; k++) step();
        chk("at_cnt_100", m_n[0] % PER, 100);
        rst_a = 1;
        step();
        chk("rst_pwm", pwm_a, 0);
        rst_a = 0;
        #1;
        chk("rst_ready", rdy_a, 1);
        count_hi(0, 2 * PER, hi);
        chk("pending_discarded", hi, 0);

        // DIV=4 instance: 1024-clk period, 0x02 gives 8 high clks.
        push(1, 8'h02, 10);
        wait_ps(1, 2000, ur);
        count_hi(1, 4 * PER, hi);
        chk("div4_highs", hi, 8);
        chk("div4_period", ps_b, 1);

        // Random traffic honouring the hold-until-accepted rule.
        rst_a = 1; step(); rst_a = 0;
        begin
            bit acc;
            acc = 0;
            for (int c = 0; c < 3000; c++) begin
                if (!vld_a || acc) begin
                    vld_a = ($urandom_range(0, 3) == 0);
                    din_a = 8'($urandom_range(0, 255));
                end
                rst_a = ($urandom_range(0, 999) == 0);
                #1;
                acc = vld_a && rdy_a;
                step();
            end
            rst_a = 0;
            vld_a = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
- Downstream stage of the sine-table sample generator.
- Accepts 8-bit unsigned samples over a valid/ready handshake and double-buffers them.
- Drives one-bit PWM; after an external RC filter this forms the analog DAC output.
- Each PWM period spans 2^DATA_W ticks. A new sample is applied only at a period boundary, so no period carries a glitched duty cycle.

Parameters:
DATA_W, 8, sample width; PWM period = 2^DATA_W ticks
DIV, 1, clock divider; one tick every DIV clk cycles (DIV >= 1)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
sample_in  input  DATA_W  unsigned sample; 0 = 0% duty
sample_valid  input  1  sample_in valid this cycle
sample_ready  output  1  block can accept a sample this cycle
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse when a new PWM period begins
underrun  output  1  one-cycle pulse when a boundary finds no pending sample

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - div_cnt=0, cnt=0, active=0, pend=0, pend_valid=0.
  - pwm_out=0, period_start=0, underrun=0.
  - sample_ready=0 while rst=1.
- Prescaler:
  - tick=1 when div_cnt==DIV-1; div_cnt then returns to 0, otherwise it increments.
  - With DIV=1, tick is 1 every cycle.
- Period counter cnt (DATA_W bits):
  - Increments on tick.
  - Wraps from 2^DATA_W-1 to 0.
  - No other wrap or saturation.
- Handshake:
  - sample_ready = !pend_valid && !rst. This path is combinational from registers only; there is no path from sample_valid to sample_ready.
  - A transfer occurs when sample_valid && sample_ready. Then pend<=sample_in and pend_valid<=1.
  - sample_in is ignored when sample_ready=0. The upstream stage must hold the sample until it is accepted.
- Boundary: the cycle with tick && cnt==2^DATA_W-1.
  - If pend_valid: active<=pend, pend_valid<=0.
  - Else: active holds its value and underrun<=1 for one cycle.
  - period_start<=1 for one cycle.
- Simultaneous transfer and boundary:
  - A transfer cannot coincide with a boundary load, because the load requires pend_valid=1, which forces ready=0.
  - If pend_valid=0 at the boundary, an incoming transfer on that same cycle fills pend and is applied at the next boundary. Underrun still pulses.
- PWM compare: pwm_out <= (cnt < active), unsigned.
  - Output lags the register state by 1 clk.
  - active=0 gives a constant 0.
  - active=2^DATA_W-1 gives (2^DATA_W-1)/2^DATA_W duty; 100% duty is not reachable.
- Latency from accepted sample to first affected pwm_out:
  - Up to one full period plus 1 clk when pend is empty.
  - Up to two periods when one sample is already pending.
- Reset mid-period: every register returns to its reset value on the next edge. A pending sample is discarded. The next period starts at cnt=0.

Optional Feature:
- Macro: PWM_DAC_UNDERRUN_CNT_EN.
- Defined:
  - Adds output port underrun_cnt [15:0], a saturating count of underrun pulses.
  - Cleared by rst.
  - Holds at 16'hFFFF.
- Undefined:
  - The port and its counter are absent.
  - The underrun pulse is unchanged.

Decomposition:
- Package pwm_dac_pkg holds:
  - default DATA_W (8) and DIV (1);
  - localparam CNT_MAX = 2^DATA_W-1;
  - UNDERRUN_CNT_W = 16.
- One sub-module, pwm_dac_prescaler: inputs clk and rst, output tick, parameter DIV.
- The handshake buffer, counter and compare logic stay in pwm_dac.

Test Plan (DATA_W=8; DIV=1 unless noted):
1. Push 0x40 after reset. Expected:
   - 0x40 loaded at the first boundary (clk 256 after reset).
   - Every later period has exactly 64 high and 192 low cycles.
   - period_start pulses every 256 clks.
2. Push 0x00, then 0xFF. Expected:
   - One period with pwm_out constantly 0.
   - Next period with 255 high cycles and 1 low.
3. Push two samples (0x10, 0x20) back to back with valid held. Expected:
   - sample_ready drops after 0x10 and rises the cycle after the boundary that loads 0x10.
   - 0x20 is accepted then and applied one period later.
   - No sample is lost.
4. No push after the first sample (0x80). Expected:
   - underrun pulses at each later boundary.
   - pwm_out holds 128/256 duty.
   - With PWM_DAC_UNDERRUN_CNT_EN defined, underrun_cnt reads 3 after 3 boundaries.
5. Assert rst at cnt=100 with 0x80 active and 0x30 pending. Expected:
   - On the next clk, pwm_out=0, sample_ready=1, and cnt restarts from 0.
   - 0x30 is never output.
6. DIV=4, push 0x02. Expected:
   - Period is 1024 clks.
   - pwm_out is high for 8 clks per period.
